ebm_billing_ctrl: RTL and testbench

Parametrised, clocked billing controller for the electricity billing machine. It holds a per-meter register file of the last billed reading and the outstanding balance, and accepts one request at a time over a valid/ready handshake. Supported requests are query consumption, generate a slab-tariff bill, record a payment, and read the balance. Each result is returned as a one-cycle response pulse with a status code. It sits between the front-panel/menu logic and the display/receipt logic.

---
 rtl/ebm_billing_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_ebm_billing_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebm_billing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ebm_billing_ctrl
// Description : Billing controller for the electricity billing machine.
//               Holds per-meter last-billed reading and outstanding balance,
//               serves QUERY / BILL / PAY / BALANCE requests one at a time
//               over a valid/ready handshake and returns a one-cycle
//               response pulse with a status code.
// Revision    : 1.0 - initial release
// ============================================================================
module ebm_billing_ctrl #(
  parameter int NUM_METERS   = 10,
  parameter int METER_W      = 12,
  parameter int BASE_METER   = 1000,
  parameter int UNITS_W      = 13,
  parameter int AMT_W        = 20,
  parameter int SLAB1        = 100,
  parameter int SLAB2        = 300,
  parameter int RATE1        = 3,
  parameter int RATE2        = 5,
  parameter int RATE3        = 8,
  parameter int FIXED_CHARGE = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [METER_W-1:0] meter_number,
  input  logic [UNITS_W-1:0] reading,
  input  logic [AMT_W-1:0]   pay_amount,
  output logic               resp_valid,
  output logic [1:0]         resp_status,
  output logic [UNITS_W-1:0] resp_units,
  output logic [AMT_W-1:0]   resp_amount,
  output logic               busy
);

  localparam int IDX_W  = (NUM_METERS > 1) ? $clog2(NUM_METERS) : 1;
  localparam int CALC_W = AMT_W + UNITS_W + 4;

  localparam logic [1:0] C_OP_QUERY   = 2'b00;
  localparam logic [1:0] C_OP_BILL    = 2'b01;
  localparam logic [1:0] C_OP_PAY     = 2'b10;
  localparam logic [1:0] C_OP_BALANCE = 2'b11;

  localparam logic [1:0] C_ST_OK        = 2'b00;
  localparam logic [1:0] C_ST_NOT_FOUND = 2'b01;
  localparam logic [1:0] C_ST_BAD_READ  = 2'b10;
  localparam logic [1:0] C_ST_OVERPAY   = 2'b11;

  // Meter range bounds carry one extra bit so the upper bound cannot wrap.
  localparam logic [METER_W:0]   C_LO      = (METER_W+1)'(BASE_METER);
  localparam logic [METER_W:0]   C_HI      = (METER_W+1)'(BASE_METER + NUM_METERS - 1);
  localparam logic [METER_W-1:0] C_BASE    = METER_W'(BASE_METER);

  localparam logic [CALC_W-1:0]  C_SLAB1   = CALC_W'(SLAB1);
  localparam logic [CALC_W-1:0]  C_SLAB2   = CALC_W'(SLAB2);
  localparam logic [CALC_W-1:0]  C_SPAN    = CALC_W'(SLAB2 - SLAB1);
  localparam logic [CALC_W-1:0]  C_RATE1   = CALC_W'(RATE1);
  localparam logic [CALC_W-1:0]  C_RATE2   = CALC_W'(RATE2);
  localparam logic [CALC_W-1:0]  C_RATE3   = CALC_W'(RATE3);
  localparam logic [CALC_W-1:0]  C_FIXED   = CALC_W'(FIXED_CHARGE);
  localparam logic [CALC_W-1:0]  C_AMT_MAX = {{(CALC_W-AMT_W){1'b0}}, {AMT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_CALC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [METER_W-1:0]   meter_q;
  logic [UNITS_W-1:0]   reading_q;
  logic [AMT_W-1:0]     pay_q;
  logic [IDX_W-1:0]     idx_q;
  logic [1:0]           pend_status_q;
  logic [UNITS_W-1:0]   pend_units_q;
  logic [AMT_W-1:0]     pend_amount_q;
  logic                 resp_valid_q;
  logic [1:0]           resp_status_q;
  logic [UNITS_W-1:0]   resp_units_q;
  logic [AMT_W-1:0]     resp_amount_q;

  logic [UNITS_W-1:0]   last_q [NUM_METERS];
  logic [AMT_W-1:0]     bal_q  [NUM_METERS];

  logic                 w_in_range;
  logic [IDX_W-1:0]     w_idx;
  logic [UNITS_W-1:0]   w_last;
  logic [AMT_W-1:0]     w_bal;
  logic                 w_bad;
  logic [UNITS_W-1:0]   w_units;
  logic [CALC_W-1:0]    w_u;
  logic [CALC_W-1:0]    w_s1;
  logic [CALC_W-1:0]    w_s2;
  logic [CALC_W-1:0]    w_s3;
  logic [CALC_W-1:0]    w_bill_raw;
  logic [AMT_W-1:0]     w_bill;
  logic [AMT_W:0]       w_bal_sum;
  logic [AMT_W-1:0]     w_bal_add;
  logic                 w_overpay;
  logic [AMT_W-1:0]     w_bal_sub;

  logic [1:0]           status_d;
  logic [UNITS_W-1:0]   units_d;
  logic [AMT_W-1:0]     amount_d;
  logic                 we_last_d;
  logic                 we_bal_d;
  logic [AMT_W-1:0]     bal_wdata_d;

  // Address decode of the captured meter number.
  assign w_in_range = ({1'b0, meter_q} >= C_LO) && ({1'b0, meter_q} <= C_HI);
  assign w_idx      = IDX_W'(meter_q - C_BASE);

  // Database read of the selected meter; idx_q is only loaded for in-range meters.
  assign w_last    = last_q[idx_q];
  assign w_bal     = bal_q[idx_q];
  assign w_bad     = reading_q < w_last;
  assign w_units   = reading_q - w_last;
  assign w_u       = CALC_W'(w_units);

  // Slab tariff at wide precision, then saturated into the amount width.
  assign w_s1       = (w_u > C_SLAB1) ? C_SLAB1 : w_u;
  assign w_s2       = (w_u > C_SLAB2) ? C_SPAN : ((w_u > C_SLAB1) ? (w_u - C_SLAB1) : '0);
  assign w_s3       = (w_u > C_SLAB2) ? (w_u - C_SLAB2) : '0;
  assign w_bill_raw = w_s1 * C_RATE1 + w_s2 * C_RATE2 + w_s3 * C_RATE3 + C_FIXED;
  assign w_bill     = (w_bill_raw > C_AMT_MAX) ? {AMT_W{1'b1}} : w_bill_raw[AMT_W-1:0];

  // Balance update candidates: saturating add for bills, checked subtract for payments.
  assign w_bal_sum = {1'b0, w_bal} + {1'b0, w_bill};
  assign w_bal_add = w_bal_sum[AMT_W] ? {AMT_W{1'b1}} : w_bal_sum[AMT_W-1:0];
  assign w_overpay = pay_q > w_bal;
  assign w_bal_sub = w_bal - pay_q;

  // Result and write-enable selection for the operation being calculated.
  always_comb begin
    status_d    = C_ST_OK;
    units_d     = '0;
    amount_d    = '0;
    we_last_d   = 1'b0;
    we_bal_d    = 1'b0;
    bal_wdata_d = w_bal;
    case (op_q)
      C_OP_QUERY: begin
        if (w_bad) status_d = C_ST_BAD_READ;
        else       units_d  = w_units;
      end
      C_OP_BILL: begin
        if (w_bad) begin
          status_d = C_ST_BAD_READ;
        end else begin
          units_d     = w_units;
          amount_d    = w_bill;
          we_last_d   = 1'b1;
          we_bal_d    = 1'b1;
          bal_wdata_d = w_bal_add;
        end
      end
      C_OP_PAY: begin
        if (w_overpay) begin
          status_d = C_ST_OVERPAY;
          amount_d = w_bal;
        end else begin
          amount_d    = w_bal_sub;
          we_bal_d    = 1'b1;
          bal_wdata_d = w_bal_sub;
        end
      end
      C_OP_BALANCE: amount_d = w_bal;
      default:      status_d = C_ST_OK;
    endcase
  end

  // Meter database: cleared by reset, written only on the CALC->RESP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_METERS; i++) begin
        last_q[i] <= '0;
        bal_q[i]  <= '0;
      end
    end else if (state_q == S_CALC) begin
      if (we_last_d) last_q[idx_q] <= reading_q;
      if (we_bal_d)  bal_q[idx_q]  <= bal_wdata_d;
    end
  end

  // Request FSM: capture, lookup, calculate, then publish a one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      meter_q       <= '0;
      reading_q     <= '0;
      pay_q         <= '0;
      idx_q         <= '0;
      pend_status_q <= '0;
      pend_units_q  <= '0;
      pend_amount_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_units_q  <= '0;
      resp_amount_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            meter_q   <= meter_number;
            reading_q <= reading;
            pay_q     <= pay_amount;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_in_range) begin
            idx_q   <= w_idx;
            state_q <= S_CALC;
          end else begin
            pend_status_q <= C_ST_NOT_FOUND;
            pend_units_q  <= '0;
            pend_amount_q <= '0;
            state_q       <= S_RESP;
          end
        end
        S_CALC: begin
          pend_status_q <= status_d;
          pend_units_q  <= units_d;
          pend_amount_q <= amount_d;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q  <= 1'b1;
          resp_status_q <= pend_status_q;
          resp_units_q  <= pend_units_q;
          resp_amount_q <= pend_amount_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_units  = resp_units_q;
  assign resp_amount = resp_amount_q;

endmodule
`default_nettype wire

// File: tb/tb_ebm_billing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ebm_billing_ctrl
// Description : Self-checking bench for ebm_billing_ctrl: directed vector
//               table, randomized traffic against a reference model, and
//               hand-written reset / busy / saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ebm_billing_ctrl;

  localparam int BASE = 1000;
  localparam int NM   = 10;
  localparam longint AMAX = 64'd1048575;
  localparam logic [1:0] QUERY = 2'b00, BILL = 2'b01, PAY = 2'b10, BALANCE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [11:0] meter_number = '0;
  logic [12:0] reading = '0;
  logic [19:0] pay_amount = '0;
  logic [15:0] pay16 = '0;

  logic        req_ready, resp_valid, busy;
  logic [1:0]  resp_status;
  logic [12:0] resp_units;
  logic [19:0] resp_amount;

  logic        b_req_ready, b_resp_valid, b_busy;
  logic [1:0]  b_resp_status;
  logic [12:0] b_resp_units;
  logic [15:0] b_resp_amount;

  int total = 0;
  int bad   = 0;

  longint m_last [NM];
  longint m_bal  [NM];

  ebm_billing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .meter_number(meter_number), .reading(reading),
    .pay_amount(pay_amount), .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_units(resp_units), .resp_amount(resp_amount), .busy(busy)
  );

  ebm_billing_ctrl #(.AMT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_op(req_op), .meter_number(meter_number), .reading(reading),
    .pay_amount(pay16), .resp_valid(b_resp_valid), .resp_status(b_resp_status),
    .resp_units(b_resp_units), .resp_amount(b_resp_amount), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NM; i++) begin
      m_last[i] = 0;
      m_bal[i]  = 0;
    end
  endfunction

  // Reference behaviour straight from the tariff and balance rules.
  function automatic void model(input logic [1:0] op, input int meter, input longint rd,
                                input longint pay, output int st, output longint u,
                                output longint amt);
    int i;
    longint bill;
    st = 0; u = 0; amt = 0;
    if (meter < BASE || meter >= BASE + NM) begin
      st = 1;
      return;
    end
    i = meter - BASE;
    case (op)
      QUERY, BILL: begin
        if (rd < m_last[i]) begin
          st = 2;
        end else begin
          u = rd - m_last[i];
          if (op == BILL) begin
            bill = lmin(u, 100) * 3 + lmin(lmax(u - 100, 0), 200) * 5
                 + lmax(u - 300, 0) * 8 + 50;
            amt       = lmin(bill, AMAX);
            m_bal[i]  = lmin(m_bal[i] + amt, AMAX);
            m_last[i] = rd;
          end
        end
      end
      PAY: begin
        if (pay > m_bal[i]) begin
          st  = 3;
          amt = m_bal[i];
        end else begin
          m_bal[i] = m_bal[i] - pay;
          amt      = m_bal[i];
        end
      end
      default: amt = m_bal[i];
    endcase
  endfunction

  // One handshake; returns number of edges from accept to the sampled response.
  task automatic do_req(input logic [1:0] op, input int meter, input int rd, input int pay,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", req_ready, 1);
    req_valid    = 1'b1;
    req_op       = op;
    meter_number = 12'(meter);
    reading      = 13'(rd);
    pay_amount   = 20'(pay);
    pay16        = 16'(pay);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_op       = 2'($urandom);
    meter_number = 12'($urandom);
    reading      = 13'($urandom);
    pay_amount   = 20'($urandom);
    pay16        = 16'($urandom);
    @(posedge clk);
    #1;
    chk("busy_after_accept", busy, 1);
    chk("resp_pulse_single", resp_valid, 0);
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
  endtask

  task automatic run_model(input logic [1:0] op, input int meter, input int rd, input int pay);
    int lat, st;
    longint u, a;
    do_req(op, meter, rd, pay, lat);
    model(op, meter, rd, pay, st, u, a);
    chk("model_latency", lat, (st == 1) ? 2 : 3);
    chk("model_status", resp_status, st);
    chk("model_units", resp_units, u);
    chk("model_amount", resp_amount, a);
  endtask

  typedef struct {
    logic [1:0] op;
    int         meter;
    int         rd;
    int         pay;
    logic [1:0] st;
    int         units;
    int         amt;
    int         lat;
  } vec_t;

  initial begin
    vec_t   vec [20];
    int     lat, st, cnt, meter, rd, pay, idx;
    longint u, a;

    vec[0]  = '{BILL,    1003, 250,  0,    2'd0, 250, 1100, 3};
    vec[1]  = '{BALANCE, 1003, 0,    0,    2'd0, 0,   1100, 3};
    vec[2]  = '{BILL,    1003, 700,  0,    2'd0, 450, 2550, 3};
    vec[3]  = '{BALANCE, 1003, 0,    0,    2'd0, 0,   3650, 3};
    vec[4]  = '{QUERY,   1003, 700,  0,    2'd0, 0,   0,    3};
    vec[5]  = '{PAY,     1003, 0,    4000, 2'd3, 0,   3650, 3};
    vec[6]  = '{PAY,     1003, 0,    3600, 2'd0, 0,   50,   3};
    vec[7]  = '{QUERY,   999,  0,    0,    2'd1, 0,   0,    2};
    vec[8]  = '{BILL,    1010, 500,  0,    2'd1, 0,   0,    2};
    vec[9]  = '{BILL,    1003, 100,  0,    2'd2, 0,   0,    3};
    vec[10] = '{QUERY,   1003, 750,  0,    2'd0, 50,  0,    3};
    vec[11] = '{BALANCE, 1003, 0,    0,    2'd0, 0,   50,   3};
    vec[12] = '{BILL,    1009, 100,  0,    2'd0, 100, 350,  3};
    vec[13] = '{BILL,    1000, 101,  0,    2'd0, 101, 355,  3};
    vec[14] = '{BILL,    1001, 300,  0,    2'd0, 300, 1350, 3};
    vec[15] = '{BILL,    1002, 301,  0,    2'd0, 301, 1358, 3};
    vec[16] = '{PAY,     1009, 0,    350,  2'd0, 0,   0,    3};
    vec[17] = '{QUERY,   1001, 10,   0,    2'd2, 0,   0,    3};
    vec[18] = '{BALANCE, 1010, 0,    0,    2'd1, 0,   0,    2};
    vec[19] = '{PAY,     1000, 0,    0,    2'd0, 0,   355,  3};

    // Reset state
    model_clear();
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_units", resp_units, 0);
    chk("rst_resp_amount", resp_amount, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Directed vector table, issued back to back
    for (int i = 0; i < 20; i++) begin
      do_req(vec[i].op, vec[i].meter, vec[i].rd, vec[i].pay, lat);
      model(vec[i].op, vec[i].meter, vec[i].rd, vec[i].pay, st, u, a);
      chk($sformatf("vec%0d_latency", i), lat, vec[i].lat);
      chk($sformatf("vec%0d_status", i), resp_status, vec[i].st);
      chk($sformatf("vec%0d_units", i), resp_units, vec[i].units);
      chk($sformatf("vec%0d_amount", i), resp_amount, vec[i].amt);
    end

    // Requests presented while busy are ignored, not queued
    @(negedge clk);
    req_valid = 1'b1; req_op = BALANCE; meter_number = 12'd1003; reading = '0;
    @(posedge clk);
    #1;
    req_op = BILL; reading = 13'd8191;
    @(posedge clk);
    #1;
    chk("busy_hold_ready", req_ready, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    model(BALANCE, 1003, 0, 0, st, u, a);
    chk("busy_ignore_resp", resp_valid, 1);
    chk("busy_ignore_amount", resp_amount, a);
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid) cnt++;
    end
    chk("busy_ignore_no_queue", cnt, 0);
    run_model(QUERY, 1003, 750, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      meter = BASE - 3 + int'($urandom_range(0, NM + 5));
      idx   = (meter >= BASE && meter < BASE + NM) ? meter - BASE : 0;
      if ($urandom_range(0, 9) == 0)
        rd = int'(lmax(m_last[idx] - 1 - longint'($urandom_range(0, 50)), 0));
      else
        rd = int'(lmin(m_last[idx] + longint'($urandom_range(0, 700)), 8191));
      if ($urandom_range(0, 1) == 0 && m_bal[idx] > 0)
        pay = int'($urandom_range(0, 32'(m_bal[idx])));
      else
        pay = int'(lmin(m_bal[idx] + 1 + longint'($urandom_range(0, 1000)), AMAX));
      run_model(2'($urandom_range(0, 3)), meter, rd, pay);
    end

    // Reset pulse in the middle of a BILL calculation
    @(negedge clk);
    req_valid = 1'b1; req_op = BILL; meter_number = 12'd1003; reading = 13'd8000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midcalc_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_valid", resp_valid, 0);
    chk("midcalc_rst_busy", busy, 0);
    chk("midcalc_rst_amount", resp_amount, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("midcalc_ready_after", req_ready, 1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid) cnt++;
    end
    chk("midcalc_no_resp", cnt, 0);
    do_req(BALANCE, 1003, 0, 0, lat);
    chk("midcalc_balance_zero", resp_amount, 0);
    chk("midcalc_balance_lat", lat, 3);

    // Balance saturation on the 16-bit amount instance
    run_model(BILL, 1000, 8191, 0);
    chk("sat16_first_units", b_resp_units, 8191);
    chk("sat16_first_amount", b_resp_amount, 64478);
    for (int k = 0; k < 21; k++) run_model(BILL, 1000, 8191, 0);
    chk("sat16_zero_bill", b_resp_amount, 50);
    run_model(BALANCE, 1000, 0, 0);
    chk("sat16_bal_below", b_resp_amount, 65528);
    run_model(BILL, 1000, 8191, 0);
    run_model(BALANCE, 1000, 0, 0);
    chk("sat16_bal_sat", b_resp_amount, 65535);
    run_model(BILL, 1000, 8191, 0);
    run_model(BALANCE, 1000, 0, 0);
    chk("sat16_bal_hold", b_resp_amount, 65535);
    chk("sat16_status", b_resp_status, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
